// File: rtl/sr_ff_pkg.sv
// Shared types for the sr_ff set/reset flip-flop bank: the per-bit {s,r} command and its decoder.
package sr_ff_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_CLR     = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_cmd_e;

  function automatic sr_cmd_e sr_decode(input logic s, input logic r);
    sr_cmd_e cmd;
    case ({s, r})
      2'b00:   cmd = SR_HOLD;
      2'b01:   cmd = SR_CLR;
      2'b10:   cmd = SR_SET;
      2'b11:   cmd = SR_INVALID;
      default: cmd = SR_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// Single SR storage bit with synchronous reset and enable; S=R=1 holds.
// SR_FF_CONFLICT_FLAG_EN adds a registered one-cycle conflict pulse.
module sr_ff_cell
  import sr_ff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic rst_val,
`ifdef SR_FF_CONFLICT_FLAG_EN
  output logic conflict,
`endif
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (sr_decode(s, r))
        SR_CLR:     q_d = 1'b0;
        SR_SET:     q_d = 1'b1;
        SR_INVALID: q_d = q_q;
        SR_HOLD:    q_d = q_q;
        default:    q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef SR_FF_CONFLICT_FLAG_EN
  logic conflict_q;
  logic conflict_d;

  // Pulse only on an enabled S=R=1 request; never sticky.
  always_comb begin
    conflict_d = 1'b0;
    if (en && (sr_decode(s, r) == SR_INVALID)) begin
      conflict_d = 1'b1;
    end else begin
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;
`endif

endmodule

// File: rtl/sr_ff.sv
// WIDTH-bit bank of independent SR flip-flops sharing clock, reset and enable.
// SR_FF_CONFLICT_FLAG_EN exposes the per-bit registered conflict output.
module sr_ff
  import sr_ff_pkg::*;
#(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
`ifdef SR_FF_CONFLICT_FLAG_EN
  output logic [WIDTH-1:0] conflict,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  if (WIDTH < 1) begin : g_width_check
    $error("sr_ff: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .s        (s[i]),
      .r        (r[i]),
      .rst_val  (RESET_VAL[i]),
`ifdef SR_FF_CONFLICT_FLAG_EN
      .conflict (conflict[i]),
`endif
      .q        (q[i])
    );
  end

  assign qn = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: directed test-plan steps followed by random traffic vs a bit-rule model.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] q0, qn0, q1, qn1;
`ifdef SR_FF_CONFLICT_FLAG_EN
  logic [3:0] c0, c1;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] m_q0, m_q1, m_c;

  localparam logic [3:0] RV0 = 4'b0000;
  localparam logic [3:0] RV1 = 4'b1011;

  always #5 clk = ~clk;

  sr_ff #(.WIDTH(4), .RESET_VAL(RV0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r),
`ifdef SR_FF_CONFLICT_FLAG_EN
    .conflict(c0),
`endif
    .q(q0), .qn(qn0)
  );

  sr_ff #(.WIDTH(4), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .s(s), .r(r),
`ifdef SR_FF_CONFLICT_FLAG_EN
    .conflict(c1),
`endif
    .q(q1), .qn(qn1)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: each bit applies the plain SR truth table; S=R=1 and en=0 keep the old value.
  function automatic logic [3:0] next_q(input logic [3:0] cur, input logic [3:0] rv,
                                        input logic rst, input logic e,
                                        input logic [3:0] sv, input logic [3:0] rr);
    logic [3:0] n;
    n = cur;
    if (rst) return rv;
    if (!e) return cur;
    for (int i = 0; i < 4; i++) begin
      if (sv[i] && !rr[i]) n[i] = 1'b1;
      else if (!sv[i] && rr[i]) n[i] = 1'b0;
    end
    return n;
  endfunction

  task automatic step(input logic rst, input logic e, input logic [3:0] sv, input logic [3:0] rr);
    @(negedge clk);
    reset = rst; en = e; s = sv; r = rr;
    @(posedge clk);
    m_q0 = next_q(m_q0, RV0, rst, e, sv, rr);
    m_q1 = next_q(m_q1, RV1, rst, e, sv, rr);
    m_c  = (rst || !e) ? 4'b0000 : (sv & rr);
    #1;
    chk("q0", q0, m_q0);
    chk("qn0", qn0, ~m_q0);
    chk("q1", q1, m_q1);
    chk("qn1", qn1, ~m_q1);
`ifdef SR_FF_CONFLICT_FLAG_EN
    chk("conflict0", c0, m_c);
    chk("conflict1", c1, m_c);
`endif
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; s = 4'b0000; r = 4'b0000;
    m_q0 = 4'bxxxx; m_q1 = 4'bxxxx; m_c = 4'b0000;

    // Reset
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk("reset_q0", q0, 4'b0000);
    chk("reset_qn0", qn0, 4'b1111);
    chk("reset_q1", q1, RV1);

    // Clear then set
    step(1'b0, 1'b1, 4'b0000, 4'b1111);
    chk("clr_q0", q0, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 4'b0000);
    chk("set_q0", q0, 4'b1111);

    // Invalid holds, conflict pulses one cycle
    step(1'b0, 1'b1, 4'b1111, 4'b1111);
    chk("inv_q0", q0, 4'b1111);
`ifdef SR_FF_CONFLICT_FLAG_EN
    chk("inv_conf", c0, 4'b1111);
`endif
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
`ifdef SR_FF_CONFLICT_FLAG_EN
    chk("inv_conf_clear", c0, 4'b0000);
`endif

    // Enable gating
    step(1'b0, 1'b1, 4'b0000, 4'b1111);
    step(1'b0, 1'b0, 4'b1111, 4'b0000);
    chk("gate_hold0", q0, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 4'b1111);
    chk("gate_hold1", q0, 4'b1111);
    step(1'b0, 1'b0, 4'b1111, 4'b1111);
`ifdef SR_FF_CONFLICT_FLAG_EN
    chk("gate_noconf", c0, 4'b0000);
`endif

    // Reset priority over enabled set
    step(1'b0, 1'b1, 4'b1111, 4'b0000);
    step(1'b1, 1'b1, 4'b1111, 4'b0000);
    chk("rstprio_q0", q0, 4'b0000);
    chk("rstprio_q1", q1, RV1);

    // Per-bit independence
    step(1'b0, 1'b1, 4'b0000, 4'b1111);
    step(1'b0, 1'b1, 4'b1010, 4'b0110);
    chk("width_q0", q0, 4'b1000);
`ifdef SR_FF_CONFLICT_FLAG_EN
    chk("width_conf", c0, 4'b0010);
`endif

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
